booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin scheduler that shares one serial-load Booth multiplier (16-bit operands, 32-bit product) among NREQ requesters. It accepts one request per transaction and sequences the multiplier's two-phase operand load over its single data bus: multiplicand with `start`, then multiplier while `ldq` is high. It then waits for `done`, captures the product, and returns it tagged with the requester index. It sits between client blocks and the multiplier top.

## Interface
- `NREQ`, 4: number of requesters, range 2..8.
- `W`, 16: operand width; the product is 2*W.
- `FLUSH_CYCLES`, 2*W+4: post-reset drain interval before the first grant.
- `TIMEOUT`, 4*W: watchdog limit in RUN; used only with `BOOTH_ARB_TIMEOUT_EN`.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: per-requester request.
- `req_a` in NREQ*W: multiplicands; requester i occupies bits [i*W +: W].
- `req_b` in NREQ*W: multipliers, same packing.
- `req_ready` out NREQ: one-hot, one-cycle accept pulse.
- `mul_start` out 1: start pulse to the multiplier.
- `mul_data` out W: multiplier operand bus.
- `mul_ldq` in 1: multiplier ready to load Q.
- `mul_done` in 1: multiplier finished.
- `mul_product` in 2*W: {A,Q} from the multiplier.
- `rsp_valid` out 1: result available.
- `rsp_id` out clog2(NREQ): requester index of the result.
- `rsp_product` out 2*W: signed product.
- `rsp_err` out 1: timeout abort; tied 0 without the macro.
- `rsp_ready` in 1: consumer accepts the result.

## Operation
- States: FLUSH, IDLE, LOAD_M, WAIT_LDQ, RUN, RESP.
- FLUSH: entered on reset. An internal counter runs FLUSH_CYCLES cycles, then the block moves to IDLE. This drains any operation left in the unreset multiplier.
- IDLE:
  - If any `req_valid` is high, grant by round-robin and go to LOAD_M.
  - Priority starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins first.
  - In the grant cycle, `req_ready[g]`=1 and a/b/g are registered.
- LOAD_M: `mul_start`=1 for exactly one cycle, `mul_data`=A. Next state is WAIT_LDQ.
- WAIT_LDQ: `mul_data` is A while `mul_ldq`=0 and B (combinationally) while `mul_ldq`=1. Go to RUN on the first cycle `mul_ldq`=1.
- RUN:
  - `mul_data`=B.
  - On `mul_done`=1, register `mul_product` into `rsp_product` and go to RESP.
  - `mul_done` is ignored in every other state.
- RESP: `rsp_valid`=1, with `rsp_id`, `rsp_product` and `rsp_err` held stable. On `rsp_valid && rsp_ready`, go to IDLE.
- No new grant occurs until the response is taken; there is at most one transaction in flight.
- Requests that lose arbitration stay pending; requesters must hold valid/operands until `req_ready`.
- Product is two's-complement; the arbiter does no arithmetic.

## Timing
- Reset values: all outputs 0; state FLUSH; last_grant NREQ-1.
- Reset mid-operation clears everything immediately and re-enters FLUSH; no response is issued for the aborted job.
- The grant happens in IDLE cycle t; `mul_start` is asserted in t+1.
- `mul_ldq` seen in cycle u: B is on `mul_data` in u and in every cycle after, until RESP.
- `mul_done` seen in cycle v: `rsp_valid` is asserted in v+1.
- Minimum back-to-back spacing is one IDLE cycle after the RESP handshake.
- `req_valid` deasserting before grant is legal; the request is not taken.

## Configuration
- `BOOTH_ARB_TIMEOUT_EN` defined: a watchdog counter runs in WAIT_LDQ+RUN.
  - When it reaches TIMEOUT without `mul_done`, go to RESP with `rsp_err`=1 and `rsp_product`=0.
  - Then go to FLUSH instead of IDLE after the handshake.
- Not defined: no counter; the block waits indefinitely and `rsp_err` is constant 0.

## Structure
- Shared package `booth_pkg`: state enum, W default, and product-width constant 2*W.
- One sub-module, `rr_arbiter` (NREQ-wide request vector plus an update strobe, producing a one-hot grant and index). The FSM and the operand/result registers stay in the top.

## Test plan
- Single requester 1, a=10, b=-5 → `mul_start` one cycle; B driven once `mul_ldq` is seen; `rsp_id`=1, `rsp_product`=32'hFFFFFFCE.
- Requesters 0 and 2 valid together (3×4, 7×-7) → 0 is served first (12), then 2 (32'hFFFFFFCF); exactly one `req_ready` pulse each.
- All four requesters valid continuously for 8 jobs → grant order 0,1,2,3,0,1,2,3.
- `rsp_ready` held low 5 cycles → `rsp_valid`/`rsp_product` stable, no new `req_ready`; the next grant comes only after the handshake.
- `rst` pulsed in RUN → outputs 0 immediately; no `req_ready` for FLUSH_CYCLES cycles; next job (-32768 × -1) returns 32'h00008000.
- With `BOOTH_ARB_TIMEOUT_EN` and the multiplier model never asserting `mul_done` → `rsp_err`=1 after TIMEOUT cycles, `rsp_product`=0, followed by FLUSH.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier arbiter.
package booth_pkg;
  localparam int W_DEF  = 16;
  localparam int PROD_W = 2 * W_DEF;

  typedef enum logic [2:0] {
    S_FLUSH, S_IDLE, S_LOAD_M, S_WAIT_LDQ, S_RUN, S_RESP
  } state_t;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/booth_mult_arbiter_if.sv
// Requester, multiplier and response bus of the Booth multiplier arbiter.
interface booth_mult_arbiter_if
  import booth_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = W_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              mul_start;
  logic [W-1:0]      mul_data;
  logic              mul_ldq;
  logic              mul_done;
  logic [2*W-1:0]    mul_product;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_product;
  logic              rsp_err;
  logic              rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, mul_ldq, mul_done, mul_product, rsp_ready,
    output req_ready, mul_start, mul_data, rsp_valid, rsp_id, rsp_product, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b, mul_ldq, mul_done, mul_product, rsp_ready,
    input  req_ready, mul_start, mul_data, rsp_valid, rsp_id, rsp_product, rsp_err
  );
endinterface

// File: rtl/booth_mult_arbiter_rr.sv
// Round-robin arbiter: priority starts one past the last granted requester.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(last_grant) + i) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  // Reset value NREQ-1 makes requester 0 the first winner.
  always_ff @(posedge clk or posedge rst)
    if (rst)         last_grant <= IDW'(NREQ - 1);
    else if (update) last_grant <= idx;
endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one serial-load Booth multiplier among NREQ requesters, one job at a time.
// Optional watchdog: define BOOTH_ARB_TIMEOUT_EN.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int W            = W_DEF,
  parameter int FLUSH_CYCLES = 2*W + 4,
  parameter int TIMEOUT      = 4*W
) (
  input logic                 clk,
  input logic                 rst,
  booth_mult_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = prod_width(W);
  localparam int CW  = $clog2(FLUSH_CYCLES + TIMEOUT + 1);

  state_t          state;
  logic [W-1:0]    op_a, op_b;
  logic [IDW-1:0]  id_r;
  logic [CW-1:0]   cnt;
  logic            start_r, rsp_vld_r;
  logic [PW-1:0]   prod_r;
  logic [W-1:0]    data;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gidx;
  logic            take;

  assign take = (state == S_IDLE) && (|bus.req_valid);

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .update (take),
    .grant  (grant),
    .idx    (gidx)
  );

  assign bus.req_ready   = take ? grant : '0;
  assign bus.mul_start   = start_r;
  assign bus.mul_data    = data;
  assign bus.rsp_valid   = rsp_vld_r;
  assign bus.rsp_id      = id_r;
  assign bus.rsp_product = prod_r;

  // B must reach the bus in the same cycle the multiplier raises ldq.
  always_comb begin
    data = '0;
    case (state)
      S_LOAD_M:   data = op_a;
      S_WAIT_LDQ: data = bus.mul_ldq ? op_b : op_a;
      S_RUN:      data = op_b;
      default:    data = '0;
    endcase
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  logic err_r;
  logic wd_hit;
  assign wd_hit      = (cnt == CW'(TIMEOUT - 1));
  assign bus.rsp_err = err_r;
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FLUSH;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      id_r      <= '0;
      start_r   <= 1'b0;
      rsp_vld_r <= 1'b0;
      prod_r    <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      err_r     <= 1'b0;
`endif
    end else begin
      case (state)
        // The multiplier itself is not reset; let any stale job run out.
        S_FLUSH:
          if (cnt == CW'(FLUSH_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        S_IDLE:
          if (take) begin
            op_a    <= bus.req_a[gidx*W +: W];
            op_b    <= bus.req_b[gidx*W +: W];
            id_r    <= gidx;
            start_r <= 1'b1;
            state   <= S_LOAD_M;
          end
        S_LOAD_M: begin
          start_r <= 1'b0;
          cnt     <= '0;
          state   <= S_WAIT_LDQ;
        end
        S_WAIT_LDQ: begin
`ifdef BOOTH_ARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
          if (wd_hit) begin
            rsp_vld_r <= 1'b1;
            prod_r    <= '0;
            err_r     <= 1'b1;
            state     <= S_RESP;
          end else if (bus.mul_ldq) begin
            state <= S_RUN;
          end
`else
          if (bus.mul_ldq) state <= S_RUN;
`endif
        end
        S_RUN: begin
          if (bus.mul_done) begin
            prod_r    <= bus.mul_product;
            rsp_vld_r <= 1'b1;
            state     <= S_RESP;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (wd_hit) begin
            rsp_vld_r <= 1'b1;
            prod_r    <= '0;
            err_r     <= 1'b1;
            state     <= S_RESP;
          end
          cnt <= cnt + 1'b1;
`endif
        end
        S_RESP:
          if (bus.rsp_ready) begin
            rsp_vld_r <= 1'b0;
`ifdef BOOTH_ARB_TIMEOUT_EN
            // A hung multiplier needs draining before it is trusted again.
            if (err_r) begin
              err_r <= 1'b0;
              cnt   <= '0;
              state <= S_FLUSH;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end
        default: state <= S_FLUSH;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural serial-load multiplier.
module tb_booth_mult_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int FC   = 2*W + 4;
  localparam int TO   = 4*W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_mult_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  booth_mult_arbiter #(.NREQ(NREQ), .W(W), .FLUSH_CYCLES(FC), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main-owned stimulus controls
  int           want [NREQ];
  logic [W-1:0] opa  [NREQ];
  logic [W-1:0] opb  [NREQ];
  int           ldq_delay, run_delay;
  bit           hang;

  // requester-owned bookkeeping
  int taken   [NREQ];
  int rdy_cnt [NREQ];
  int order[$];
  int gcyc[$];
  int onehot_bad;

  // multiplier-model-owned bookkeeping
  int           phase, mcnt, start_cnt, start_cyc, done_cyc;
  logic         a_ok, b_ok;
  logic [W-1:0] cap_a, cap_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Requesters: hold valid until the accept pulse, one job per want increment.
  initial begin
    logic [NREQ-1:0] rdy;
    for (int i = 0; i < NREQ; i++) begin taken[i] = 0; rdy_cnt[i] = 0; end
    onehot_bad    = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    forever begin
      @(negedge clk);
      rdy = bus.req_ready;
      if (rdy != '0) begin
        gcyc.push_back(cyc);
        if (!$onehot(rdy)) onehot_bad++;
        for (int i = 0; i < NREQ; i++)
          if (rdy[i]) begin order.push_back(i); rdy_cnt[i]++; end
      end
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i]) taken[i]++;
        bus.req_valid[i]       = (taken[i] < want[i]);
        bus.req_a[i*W +: W]    = opa[i];
        bus.req_b[i*W +: W]    = opb[i];
      end
    end
  end

  // Multiplier model: capture A on start, raise ldq, capture B, then done.
  initial begin
    int pa, pb;
    bus.mul_ldq = 1'b0; bus.mul_done = 1'b0; bus.mul_product = '0;
    phase = 0; mcnt = 0; start_cnt = 0; start_cyc = 0; done_cyc = 0;
    a_ok = 1'b1; b_ok = 1'b1; cap_a = '0; cap_b = '0;
    forever begin
      @(posedge clk); #1;
      bus.mul_ldq  = 1'b0;
      bus.mul_done = 1'b0;
      if (rst) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (bus.mul_start) begin
               cap_a = bus.mul_data; start_cnt++; start_cyc = cyc;
               a_ok = 1'b1; b_ok = 1'b1; mcnt = ldq_delay; phase = 1;
             end
          1: begin
               if (bus.mul_data !== cap_a) a_ok = 1'b0;
               if (mcnt == 0) begin
                 bus.mul_ldq = 1'b1; #1;
                 cap_b = bus.mul_data; mcnt = run_delay; phase = 2;
               end else mcnt--;
             end
          default: begin
               if (bus.mul_data !== cap_b) b_ok = 1'b0;
               if (mcnt == 0 && !hang) begin
                 pa = $signed(cap_a); pb = $signed(cap_b);
                 bus.mul_product = pa * pb;
                 bus.mul_done = 1'b1; done_cyc = cyc; phase = 0;
               end else if (mcnt != 0) mcnt--;
             end
        endcase
      end
    end
  end

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin rc = cyc; break; end
    end
    if (rc < 0) chk("rsp_wait_expired", 0, 1);
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    int k;
    for (k = 0; k < 2000; k++) begin
      if (order.size() >= n) break;
      @(negedge clk);
    end
    if (k == 2000) chk("grant_wait_expired", 0, 1);
  endtask

  typedef struct {
    int             id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  initial begin
    vec_t           tbl [8];
    logic [2*W-1:0] exp8 [4];
    logic [2*W-1:0] held;
    int rc, c, n, c1, good;

    tbl[0] = '{1, 16'd10,   16'hFFFB, 32'hFFFFFFCE};
    tbl[1] = '{0, 16'd3,    16'd4,    32'h0000000C};
    tbl[2] = '{2, 16'd7,    16'hFFF9, 32'hFFFFFFCF};
    tbl[3] = '{3, 16'h8000, 16'hFFFF, 32'h00008000};
    tbl[4] = '{1, 16'h8000, 16'h8000, 32'h40000000};
    tbl[5] = '{2, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[6] = '{0, 16'h0000, 16'hFFFF, 32'h00000000};
    tbl[7] = '{3, 16'hFFFF, 16'hFFFF, 32'h00000001};
    exp8[0] = 32'hFFFFFFFE; exp8[1] = 32'hFFFFFFFA;
    exp8[2] = 32'hFFFFFFF4; exp8[3] = 32'hFFFFFFEC;

    ldq_delay = 2; run_delay = 4; hang = 1'b0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin want[i] = 0; opa[i] = '0; opb[i] = '0; end

    // Requesters 0 and 2 compete straight out of reset.
    opa[0] = 16'd3; opb[0] = 16'd4; opa[2] = 16'd7; opb[2] = 16'hFFF9;
    want[0] = 1; want[2] = 1;
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_mul_data", bus.mul_data, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_product", bus.rsp_product, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; c1 = cyc;
    wait_rsp(rc);
    chk("pair_first_id", bus.rsp_id, 0);
    chk("pair_first_prod", bus.rsp_product, 32'h0000000C);
    chk("flush_len", gcyc[0], c1 + FC);
    take_rsp();
    wait_rsp(rc);
    chk("pair_second_id", bus.rsp_id, 2);
    chk("pair_second_prod", bus.rsp_product, 32'hFFFFFFCF);
    take_rsp();
    chk("pair_ready0_once", rdy_cnt[0], 1);
    chk("pair_ready2_once", rdy_cnt[2], 1);

    // Single-requester table.
    for (int v = 0; v < 8; v++) begin
      opa[tbl[v].id] = tbl[v].a; opb[tbl[v].id] = tbl[v].b;
      want[tbl[v].id]++;
      wait_rsp(rc);
      n = order.size();
      chk($sformatf("v%0d_id", v), bus.rsp_id, tbl[v].id);
      chk($sformatf("v%0d_prod", v), bus.rsp_product, tbl[v].p);
      chk($sformatf("v%0d_err", v), bus.rsp_err, 0);
      chk($sformatf("v%0d_grant", v), order[n-1], tbl[v].id);
      chk($sformatf("v%0d_bus_a", v), cap_a, tbl[v].a);
      chk($sformatf("v%0d_bus_b", v), cap_b, tbl[v].b);
      chk($sformatf("v%0d_a_held", v), a_ok, 1);
      chk($sformatf("v%0d_b_held", v), b_ok, 1);
      chk($sformatf("v%0d_start_lat", v), start_cyc, gcyc[n-1] + 1);
      chk($sformatf("v%0d_rsp_lat", v), rc, done_cyc + 1);
      take_rsp();
    end
    chk("starts_total", start_cnt, 10);

    // Stalled consumer: response must hold and no new grant may occur.
    n = order.size();
    opa[2] = 16'd5; opb[2] = 16'd6; want[2]++;
    wait_grants(n + 1);
    opa[3] = 16'hFFFE; opb[3] = 16'd3; want[3]++;
    wait_rsp(rc);
    held = bus.rsp_product;
    chk("hold_prod", held, 32'h0000001E);
    n = order.size(); good = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_product == held && bus.rsp_id == 2) good++;
    end
    chk("hold_stable", good, 5);
    chk("hold_no_grant", order.size(), n);
    c = cyc;
    take_rsp();
    wait_rsp(rc);
    chk("b2b_grant_cyc", gcyc[n], c + 1);
    chk("b2b_id", bus.rsp_id, 3);
    chk("b2b_prod", bus.rsp_product, 32'hFFFFFFFA);
    take_rsp();

    // All four continuously valid for eight jobs.
    n = order.size();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = W'(i + 1); opb[i] = W'(-(i + 2)); want[i] += 2;
    end
    for (int j = 0; j < 8; j++) begin
      wait_rsp(rc);
      chk($sformatf("rr%0d_id", j), bus.rsp_id, j % 4);
      chk($sformatf("rr%0d_prod", j), bus.rsp_product, exp8[j % 4]);
      chk($sformatf("rr%0d_order", j), order[n + j], j % 4);
      take_rsp();
    end
    chk("onehot_ready", onehot_bad, 0);

    // Reset while the multiplier is running.
    run_delay = 40;
    opa[1] = 16'd100; opb[1] = 16'd100; want[1]++;
    for (int k = 0; k < 200 && phase != 2; k++) @(negedge clk);
    chk("reached_run", phase, 2);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
    chk("mid_rst_mul_start", bus.mul_start, 0);
    chk("mid_rst_mul_data", bus.mul_data, 0);
    chk("mid_rst_rsp_id", bus.rsp_id, 0);
    chk("mid_rst_rsp_prod", bus.rsp_product, 0);
    run_delay = 4;
    opa[3] = 16'h8000; opb[3] = 16'hFFFF; want[3]++;
    repeat (2) @(negedge clk);
    rst = 1'b0; c1 = cyc; n = gcyc.size();
    wait_rsp(rc);
    chk("post_rst_flush", gcyc[n], c1 + FC);
    chk("post_rst_id", bus.rsp_id, 3);
    chk("post_rst_prod", bus.rsp_product, 32'h00008000);
    take_rsp();

`ifdef BOOTH_ARB_TIMEOUT_EN
    // Multiplier never finishes: watchdog aborts, then the block re-flushes.
    hang = 1'b1;
    opa[0] = 16'd1; opb[0] = 16'd1; want[0]++;
    wait_rsp(rc);
    chk("to_err", bus.rsp_err, 1);
    chk("to_prod", bus.rsp_product, 0);
    chk("to_latency", rc, start_cyc + TO + 1);
    c = cyc; n = gcyc.size();
    hang = 1'b0;
    want[0]++;
    take_rsp();
    wait_rsp(rc);
    chk("to_flush", gcyc[n], c + 1 + FC);
    chk("to_next_err", bus.rsp_err, 0);
    chk("to_next_prod", bus.rsp_product, 32'h00000001);
    take_rsp();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end
endmodule
